// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit that owns the HI/LO
// result registers. Multiplies use shift-add and divides use restoring
// division. Both run on magnitudes and apply the signs in a final FIX step.
// MTHI/MTLO writes complete in a single edge. The stall output holds an
// MFHI/MFLO in ID/EX while a result is still being computed.
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         abort,
  input  logic         read_hilo,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic         stall
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   counter;
  // For a multiply: upper half is the partial product and lower half is the
  // remaining multiplier bits. For a divide: upper half is the partial
  // remainder and lower half is the dividend shifting into the quotient.
  logic [2*N-1:0]  acc;
  // Multiplicand magnitude, or divisor magnitude.
  logic [N-1:0]    operand;
  logic            is_div;
  logic            neg_q;
  logic            neg_r;
  logic            dbz;

  logic [N-1:0]    a_abs;
  logic [N-1:0]    b_abs;
  logic [2*N-1:0]  step_acc;
  logic [N:0]      mul_sum;
  logic [N:0]      trial;
  logic [N-1:0]    rem_sub;
  logic [2*N-1:0]  fix_prod;
  logic [N-1:0]    fix_hi;
  logic [N-1:0]    fix_lo;

  // An MFHI/MFLO must wait whenever a multi-cycle result is pending.
  assign stall = read_hilo & busy;

  // Take operand magnitudes at start; signed ops use bit 0 of op.
  always_comb begin
    a_abs = (op[0] && inA[N-1]) ? -inA : inA;
    b_abs = (op[0] && inB[N-1]) ? -inB : inB;
  end

  // One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, operand} : {(N+1){1'b0}});
    trial    = {acc[2*N-1:N], acc[N-1]};
    // Only used when trial >= operand, and then the difference fits in N bits.
    rem_sub  = trial[N-1:0] - operand;
    step_acc = acc;
    if (!is_div) begin
      step_acc = {mul_sum, acc[N-1:1]};
    end else if (trial >= {1'b0, operand}) begin
      step_acc = {rem_sub, acc[N-2:0], 1'b1};
    end else begin
      step_acc = {acc[2*N-2:0], 1'b0};
    end
  end

  // Sign correction for the final HI/LO write. A divide by zero forces the
  // quotient to all ones. The remainder then holds the original dividend
  // once its sign is restored.
  always_comb begin
    fix_prod = neg_q ? -acc : acc;
    fix_hi   = fix_prod[2*N-1:N];
    fix_lo   = fix_prod[N-1:0];
    if (is_div) begin
      fix_hi = neg_r ? -acc[2*N-1:N] : acc[2*N-1:N];
      if (dbz) begin
        fix_lo = {N{1'b1}};
      end else begin
        fix_lo = neg_q ? -acc[N-1:0] : acc[N-1:0];
      end
    end
  end

  // Control FSM plus all registered state; abort beats both start and the FIX write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      counter     <= '0;
      acc         <= '0;
      operand     <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (!op[2]) begin
              is_div      <= op[1];
              neg_q       <= op[0] & (inA[N-1] ^ inB[N-1]);
              neg_r       <= op[0] & inA[N-1];
              dbz         <= op[1] & (inB == '0);
              operand     <= op[1] ? b_abs : a_abs;
              acc         <= {{N{1'b0}}, (op[1] ? a_abs : b_abs)};
              counter     <= CW'(N);
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
              state       <= RUN;
            end else if (!op[1]) begin
              if (op[0]) begin
                lo <= inA;
              end else begin
                hi <= inA;
              end
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          if (abort) begin
            busy    <= 1'b0;
            counter <= '0;
            state   <= IDLE;
          end else begin
            acc     <= step_acc;
            counter <= counter - CW'(1);
            if (counter == CW'(1)) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          if (!abort) begin
            hi          <= fix_hi;
            lo          <= fix_lo;
            done        <= 1'b1;
            div_by_zero <= dbz;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results for muldiv_unit.
module tb_muldiv_unit;

  localparam int N = 32;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic         clock;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] inA;
  logic [N-1:0] inB;
  logic         abort;
  logic         readHilo;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic         busy;
  logic         done;
  logic         divByZero;
  logic         stall;

  int checkCount;
  int failCount;

  muldiv_unit #(.N(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .inA         (inA),
    .inB         (inB),
    .abort       (abort),
    .read_hilo   (readHilo),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (divByZero),
    .stall       (stall)
  );

  // Free-running clock: 10-unit period, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compare one observed value against its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive the request inputs. The caller is responsible for timing.
  task automatic applyStimulus(input logic s, input logic [2:0] o,
                               input logic [N-1:0] a, input logic [N-1:0] b);
    start = s;
    op    = o;
    inA   = a;
    inB   = b;
  endtask

  // Present a one-cycle start pulse. Returns #1 after the edge that samples it.
  task automatic issueStart(input logic [2:0] o, input logic [N-1:0] a,
                            input logic [N-1:0] b);
    @(negedge clock);
    applyStimulus(1'b1, o, a, b);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Start an operation and wait a bounded time for done. Returns in the done cycle.
  task automatic runOp(input string tag, input logic [2:0] o,
                       input logic [N-1:0] a, input logic [N-1:0] b);
    int busyCycles;
    int cycles;
    issueStart(o, a, b);
    busyCycles = 0;
    cycles     = 0;
    while (!done && cycles < N + 10) begin
      if (busy) busyCycles++;
      @(posedge clock);
      #1;
      cycles++;
    end
    checkOutput({tag, " done"}, 64'(done), 64'd1);
    checkOutput({tag, " latency"}, 64'(cycles), 64'(N + 1));
    checkOutput({tag, " busy cycles"}, 64'(busyCycles), 64'(N + 1));
  endtask

  // Directed test sequence.
  initial begin
    int sawDone;
    checkCount = 0;
    failCount  = 0;
    reset      = 1'b0;
    abort      = 1'b0;
    readHilo   = 1'b0;
    applyStimulus(1'b0, 3'b000, '0, '0);

    #12;
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset dbz", 64'(divByZero), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // MULTU 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    runOp("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    checkOutput("multu hi", 64'(hi), 64'h0000_0001);
    checkOutput("multu lo", 64'(lo), 64'hFFFF_FFFE);
    @(posedge clock);
    #1;
    checkOutput("multu done pulse", 64'(done), 64'd0);

    // MULT -3 * 7 = -21
    runOp("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7);
    checkOutput("mult hi", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("mult lo", 64'(lo), 64'hFFFF_FFEB);

    // MTLO: single-edge write, no busy, no done
    issueStart(OP_MTLO, 32'h0000_1234, 32'd0);
    checkOutput("mtlo lo", 64'(lo), 64'h0000_1234);
    checkOutput("mtlo hi kept", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("mtlo busy", 64'(busy), 64'd0);
    checkOutput("mtlo done", 64'(done), 64'd0);

    // DIV -7 / 2 = -3 remainder -1
    runOp("div neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div neg lo", 64'(lo), 64'hFFFF_FFFD);
    checkOutput("div neg hi", 64'(hi), 64'hFFFF_FFFF);

    // DIV most-negative / -1 wraps, no flag
    runOp("div wrap", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("div wrap lo", 64'(lo), 64'h8000_0000);
    checkOutput("div wrap hi", 64'(hi), 64'h0000_0000);
    checkOutput("div wrap dbz", 64'(divByZero), 64'd0);

    // A start during the done cycle is accepted
    issueStart(OP_MTHI, 32'h0000_ABCD, 32'd0);
    checkOutput("done-cycle mthi hi", 64'(hi), 64'h0000_ABCD);
    checkOutput("done-cycle mthi done", 64'(done), 64'd0);

    // DIVU 5 / 0: full latency, lo all ones, hi = dividend, flag held
    runOp("divu zero", OP_DIVU, 32'd5, 32'd0);
    checkOutput("divu zero lo", 64'(lo), 64'hFFFF_FFFF);
    checkOutput("divu zero hi", 64'(hi), 64'd5);
    checkOutput("divu zero dbz", 64'(divByZero), 64'd1);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("dbz held", 64'(divByZero), 64'd1);
    issueStart(OP_MTHI, 32'h0000_0777, 32'd0);
    checkOutput("dbz cleared", 64'(divByZero), 64'd0);
    checkOutput("mthi hi", 64'(hi), 64'h0000_0777);

    // Stall is only raised while busy
    readHilo = 1'b1;
    #1;
    checkOutput("stall idle", 64'(stall), 64'd0);
    readHilo = 1'b0;

    // MULT 100 * 100 with an ignored second start, stall and abort at cycle 10
    issueStart(OP_MULT, 32'd100, 32'd100);
    issueStart(OP_MTLO, 32'h0000_DEAD, 32'd0);
    checkOutput("busy start ignored lo", 64'(lo), 64'hFFFF_FFFF);
    checkOutput("busy still", 64'(busy), 64'd1);
    readHilo = 1'b1;
    #1;
    checkOutput("stall busy", 64'(stall), 64'd1);
    readHilo = 1'b0;
    #1;
    checkOutput("stall released", 64'(stall), 64'd0);
    repeat (7) @(posedge clock);
    @(negedge clock);
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort done", 64'(done), 64'd0);
    checkOutput("abort hi kept", 64'(hi), 64'h0000_0777);
    checkOutput("abort lo kept", 64'(lo), 64'hFFFF_FFFF);
    sawDone = 0;
    repeat (N + 3) begin
      @(posedge clock);
      #1;
      if (done) sawDone = 1;
    end
    checkOutput("abort no late done", 64'(sawDone), 64'd0);

    // Abort together with start in IDLE drops the start
    @(negedge clock);
    abort = 1'b1;
    applyStimulus(1'b1, OP_MTHI, 32'h0000_0055, 32'd0);
    @(posedge clock);
    #1;
    abort = 1'b0;
    start = 1'b0;
    checkOutput("abort+start hi", 64'(hi), 64'h0000_0777);

    // Asynchronous reset in the middle of a DIV
    issueStart(OP_DIV, 32'd100, 32'd7);
    repeat (14) @(posedge clock);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset hi", 64'(hi), 64'd0);
    checkOutput("async reset lo", 64'(lo), 64'd0);
    checkOutput("async reset busy", 64'(busy), 64'd0);
    checkOutput("async reset done", 64'(done), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Fresh MULTU 6 * 7 after reset
    runOp("multu small", OP_MULTU, 32'd6, 32'd7);
    checkOutput("multu small lo", 64'(lo), 64'd42);
    checkOutput("multu small hi", 64'(hi), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
